// File: rtl/vrsm_buf_pkg.sv
// Shared types and width helpers for the result pack buffer.
package vrsm_buf_pkg;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_NUM_LANE     = 4;
  localparam int DEF_BURST_LENGTH = 128;
  localparam int DEF_DEPTH_BEATS  = 256;

  typedef enum logic [1:0] {IDLE, REQ, XFER} fsm_t;

  typedef logic [DEF_NUM_LANE-1:0][DEF_DATA_WIDTH-1:0] beat_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int len_w(input int burst);
    return $clog2(burst) + 1;
  endfunction

  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction
endpackage

// File: rtl/result_pack_buffer_pack_stage.sv
// Staging register that packs result words into beats; pads a partial beat on request.
module pack_stage
  import vrsm_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_LANE   = DEF_NUM_LANE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_accept,
  input  logic [DATA_WIDTH-1:0]          i_din,
  input  logic                           i_pad_req,
  output logic                           o_commit,
  output logic [NUM_LANE*DATA_WIDTH-1:0] o_beat,
  output logic [NUM_LANE-1:0]            o_keep,
  output logic                           o_empty
);
  localparam int LANE_W = lane_w(NUM_LANE);

  logic [NUM_LANE-1:0][DATA_WIDTH-1:0] r_lanes;
  logic [NUM_LANE-1:0][DATA_WIDTH-1:0] w_beat;
  logic [LANE_W-1:0]                   r_lane_idx;
  logic                                w_full;
  logic                                w_pad;

  assign w_full   = i_accept && (r_lane_idx == LANE_W'(NUM_LANE-1));
  assign w_pad    = i_pad_req && (r_lane_idx != '0) && !i_accept;
  assign o_commit = w_full || w_pad;
  assign o_empty  = (r_lane_idx == '0);

  // Unfilled lanes are already zero because the stage is cleared on every commit.
  always_comb begin
    w_beat = r_lanes;
    if (w_full) w_beat[NUM_LANE-1] = i_din;
  end

  assign o_beat = w_beat;
  assign o_keep = w_full ? '1 : ((NUM_LANE'(1) << r_lane_idx) - NUM_LANE'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lanes    <= '0;
      r_lane_idx <= '0;
    end else if (o_commit) begin
      r_lanes    <= '0;
      r_lane_idx <= '0;
    end else if (i_accept) begin
      r_lanes[r_lane_idx] <= i_din;
      r_lane_idx          <= r_lane_idx + LANE_W'(1);
    end
  end
endmodule

// File: rtl/result_pack_buffer.sv
// Ring buffer of packed result beats drained to DMA in request/ack bursts.
// Optional status outputs (level, burst_cnt) are built with RESULT_PACK_STATUS_EN.
module result_pack_buffer
  import vrsm_buf_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_LANE     = DEF_NUM_LANE,
  parameter int BURST_LENGTH = DEF_BURST_LENGTH,
  parameter int DEPTH_BEATS  = DEF_DEPTH_BEATS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic                             flush,
  output logic                             flush_done,
  output logic                             burst_req,
  output logic [$clog2(BURST_LENGTH):0]    burst_len,
  input  logic                             burst_ack,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_LANE*DATA_WIDTH-1:0]   dout,
  output logic [NUM_LANE-1:0]              out_keep,
  output logic                             out_last
`ifdef RESULT_PACK_STATUS_EN
  ,
  output logic [$clog2(DEPTH_BEATS):0]     level,
  output logic [15:0]                      burst_cnt
`endif
);
  localparam int PTR_W  = ptr_w(DEPTH_BEATS);
  localparam int CNT_W  = cnt_w(DEPTH_BEATS);
  localparam int LEN_W  = len_w(BURST_LENGTH);
  localparam int BEAT_W = NUM_LANE * DATA_WIDTH;

  logic [BEAT_W-1:0]   r_mem_data [DEPTH_BEATS];
  logic [NUM_LANE-1:0] r_mem_keep [DEPTH_BEATS];

  logic [PTR_W-1:0]    r_wptr, r_rptr;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic [LEN_W-1:0]    r_burst_len, r_remain;
  logic [BEAT_W-1:0]   r_dout;
  logic [NUM_LANE-1:0] r_keep;
  logic                r_flush_pending, r_flush_done, r_burst_req;
  logic                r_out_valid, r_out_last;
  fsm_t                r_state;

  logic                w_in_ready, w_accept, w_commit, w_stage_empty;
  logic                w_load, w_out_fire, w_drained;
  logic [BEAT_W-1:0]   w_beat;
  logic [NUM_LANE-1:0] w_keep;

  assign w_in_ready = (r_count < CNT_W'(DEPTH_BEATS)) && !r_flush_pending;
  assign w_accept   = in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_load     = (r_state == XFER) && (r_remain != '0) && (!r_out_valid || out_ready);
  assign w_drained  = r_flush_pending && w_stage_empty && (r_count == '0) && (r_state == IDLE);
  assign w_count_nxt = r_count + CNT_W'(w_commit) - CNT_W'(w_load);

  pack_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_LANE  (NUM_LANE)
  ) u_pack_stage (
    .clk      (clk),
    .rst      (rst),
    .i_accept (w_accept),
    .i_din    (din),
    .i_pad_req(r_flush_pending && (r_count < CNT_W'(DEPTH_BEATS))),
    .o_commit (w_commit),
    .o_beat   (w_beat),
    .o_keep   (w_keep),
    .o_empty  (w_stage_empty)
  );

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem_data[r_wptr] <= w_beat;
      r_mem_keep[r_wptr] <= w_keep;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_flush_pending <= 1'b0;
      r_flush_done    <= 1'b0;
      r_burst_req     <= 1'b0;
      r_burst_len     <= '0;
      r_remain        <= '0;
      r_out_valid     <= 1'b0;
      r_dout          <= '0;
      r_keep          <= '0;
      r_out_last      <= 1'b0;
      r_state         <= IDLE;
    end else begin
      r_flush_done <= 1'b0;
      r_count      <= w_count_nxt;
      if (w_commit) r_wptr <= r_wptr + PTR_W'(1);

      if (flush && !r_flush_pending) begin
        r_flush_pending <= 1'b1;
      end else if (w_drained) begin
        r_flush_pending <= 1'b0;
        r_flush_done    <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (r_count >= CNT_W'(BURST_LENGTH)) begin
            r_state     <= REQ;
            r_burst_req <= 1'b1;
            r_burst_len <= LEN_W'(BURST_LENGTH);
          end else if (r_flush_pending && w_stage_empty && (r_count != '0)) begin
            // count is below BURST_LENGTH here, so it fits the length field
            r_state     <= REQ;
            r_burst_req <= 1'b1;
            r_burst_len <= LEN_W'(r_count);
          end
        end
        REQ: begin
          if (burst_ack) begin
            r_state     <= XFER;
            r_burst_req <= 1'b0;
            r_remain    <= r_burst_len;
          end
        end
        XFER: begin
          if (w_load) begin
            r_out_valid <= 1'b1;
            r_dout      <= r_mem_data[r_rptr];
            r_keep      <= r_mem_keep[r_rptr];
            r_out_last  <= (r_remain == LEN_W'(1));
            r_rptr      <= r_rptr + PTR_W'(1);
            r_remain    <= r_remain - LEN_W'(1);
          end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
          end
          if (w_out_fire && r_out_last) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef RESULT_PACK_STATUS_EN
  logic [CNT_W-1:0] r_level;
  logic [15:0]      r_burst_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level     <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_level <= r_count;
      if (w_out_fire && r_out_last) r_burst_cnt <= r_burst_cnt + 16'd1;
    end
  end

  assign level     = r_level;
  assign burst_cnt = r_burst_cnt;
`endif

  assign in_ready   = w_in_ready;
  assign flush_done = r_flush_done;
  assign burst_req  = r_burst_req;
  assign burst_len  = r_burst_len;
  assign out_valid  = r_out_valid;
  assign dout       = r_dout;
  assign out_keep   = r_keep;
  assign out_last   = r_out_last;
endmodule

// File: tb/tb_result_pack_buffer.sv
// Randomized bench for result_pack_buffer against a queue-based beat/burst model.
module tb_result_pack_buffer;
  import vrsm_buf_pkg::*;

  localparam int DW = 32;
  localparam int NL = 4;
  localparam int BL = 128;
  localparam int DB = 256;

  logic          clk, rst;
  logic          in_valid, in_ready, flush, flush_done;
  logic [DW-1:0] din;
  logic          burst_req, burst_ack;
  logic [7:0]    burst_len;
  logic          out_valid, out_ready, out_last;
  logic [127:0]  dout;
  logic [3:0]    out_keep;
`ifdef RESULT_PACK_STATUS_EN
  logic [8:0]    level;
  logic [15:0]   burst_cnt;
`endif

  result_pack_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .flush(flush), .flush_done(flush_done), .burst_req(burst_req), .burst_len(burst_len),
    .burst_ack(burst_ack), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .out_keep(out_keep), .out_last(out_last)
`ifdef RESULT_PACK_STATUS_EN
    , .level(level), .burst_cnt(burst_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  beat_t      exp_q[$];
  logic [3:0] keep_q[$];
  beat_t      part;
  int         pc, committed, assigned, popped, beats_left;
  logic       flush_active, stall_prev, ack_d1, ack_d2;
  beat_t      stall_data;
  logic [3:0] stall_keep;
  logic       stall_last;
  int         hs_total, n_bursts, n_flush_done, last_len;
  beat_t      last_data, first_data;
  logic [3:0] last_keep;
  int         first_mark;
  int         n_cmp, n_bad;
  int         rdy_mode, ack_mode;
  logic       abort;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    exp_q.delete(); keep_q.delete();
    part = '0; pc = 0; committed = 0; assigned = 0; popped = 0; beats_left = 0;
    flush_active = 0; stall_prev = 0; ack_d1 = 0; ack_d2 = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (flush_done) begin
        chk("flush_done_expected", flush_active, 1'b1);
        chk("flush_done_drained", exp_q.size(), 0);
        n_flush_done++;
        flush_active = 0;
      end
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", dout, stall_data);
        chk("stall_keep", out_keep, stall_keep);
        chk("stall_last", out_last, stall_last);
      end
      if (ack_d2) chk("first_beat_latency", out_valid, 1'b1);
      else if (ack_d1) chk("no_early_beat", out_valid, 1'b0);
      if (!flush_active)
        chk("in_ready", in_ready, ((committed - popped - int'(out_valid)) < DB));
      if (burst_req) begin
        chk("burst_len", burst_len, imin(BL, committed - assigned));
        chk("req_while_xfer", beats_left, 0);
      end
      ack_d2 = ack_d1;
      ack_d1 = burst_req && burst_ack;
      if (burst_req && burst_ack) begin
        assigned += int'(burst_len);
        beats_left = int'(burst_len);
        last_len = int'(burst_len);
        n_bursts++;
      end
      if (out_valid) chk("valid_in_burst", beats_left > 0, 1'b1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("beat_underflow", 1'b1, 1'b0);
        end else begin
          chk("beat_data", dout, exp_q[0]);
          chk("beat_keep", out_keep, keep_q[0]);
          void'(exp_q.pop_front()); void'(keep_q.pop_front());
        end
        chk("out_last", out_last, beats_left == 1);
        if (hs_total == first_mark) first_data = dout;
        last_data = dout; last_keep = out_keep;
        popped++; beats_left--; hs_total++;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = dout; stall_keep = out_keep; stall_last = out_last;
      if (in_valid && in_ready) begin
        part[pc] = din;
        pc++;
        if (pc == NL) begin
          exp_q.push_back(part); keep_q.push_back(4'hF);
          committed++; part = '0; pc = 0;
        end
      end
      if (flush && pc > 0) begin
        exp_q.push_back(part); keep_q.push_back(4'((1 << pc) - 1));
        committed++; part = '0; pc = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(1));
    endcase
    case (ack_mode)
      0: burst_ack = 1'b0;
      1: burst_ack = burst_req;
      default: burst_ack = burst_req ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0);
    endcase
  end

  task automatic drive_words(input int n, input int pvalid, input bit seq, input int base);
    int sent = 0;
    int cyc = 0;
    while (sent < n && !abort && cyc < n * 20 + 3000) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(99) < pvalid);
      din = seq ? DW'(base + sent) : $urandom;
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    if (!abort) chk("drive_timeout", sent, n);
  endtask

  task automatic wait_drain(input int limit);
    int cyc = 0;
    while (!(exp_q.size() == 0 && beats_left == 0 && !out_valid) && cyc < limit) begin
      @(posedge clk); cyc++;
    end
    chk("drain_timeout", exp_q.size() == 0 && beats_left == 0, 1'b1);
  endtask

  task automatic do_flush(input bit twice, output int lat);
    int start = n_flush_done;
    @(posedge clk); #1 flush = 1'b1; flush_active = 1;
    @(posedge clk); #1 flush = twice;
    @(posedge clk); #1 flush = 1'b0;
    lat = 0;
    while (n_flush_done == start && lat < 3000) begin
      @(posedge clk); lat++;
    end
    chk("flush_done_timeout", n_flush_done > start, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_flush_done"}, flush_done, 1'b0);
    chk({tag, "_burst_req"}, burst_req, 1'b0);
    chk({tag, "_burst_len"}, burst_len, 8'd0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_dout"}, dout, 128'd0);
    chk({tag, "_out_keep"}, out_keep, 4'd0);
    chk({tag, "_out_last"}, out_last, 1'b0);
  endtask

  task automatic full_burst_test(input string tag);
    int b0 = n_bursts;
    int h0 = hs_total;
    beat_t exp0;
    exp0 = {32'd3, 32'd2, 32'd1, 32'd0};
    first_mark = hs_total;
    rdy_mode = 0; ack_mode = 1;
    drive_words(512, 100, 1'b1, 0);
    wait_drain(2000);
    chk({tag, "_bursts"}, n_bursts - b0, 1);
    chk({tag, "_len"}, last_len, 128);
    chk({tag, "_beats"}, hs_total - h0, 128);
    chk({tag, "_beat0"}, first_data, exp0);
    chk({tag, "_keep_last"}, last_keep, 4'hF);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, b0, h0, f0;
    beat_t pad_exp;
    n_cmp = 0; n_bad = 0; hs_total = 0; n_bursts = 0; n_flush_done = 0; last_len = 0;
    first_mark = -1; abort = 0;
    rst = 1'b1; in_valid = 1'b0; din = '0; flush = 1'b0; burst_ack = 1'b0; out_ready = 1'b1;
    rdy_mode = 0; ack_mode = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    full_burst_test("full");

    // partial beat padded on flush; second pulse while pending must be ignored
    b0 = n_bursts; h0 = hs_total; f0 = n_flush_done;
    ack_mode = 1;
    drive_words(6, 100, 1'b1, 32'h10);
    do_flush(1'b1, lat);
    repeat (5) @(posedge clk);
    pad_exp = {32'd0, 32'd0, 32'h15, 32'h14};
    chk("flush_bursts", n_bursts - b0, 1);
    chk("flush_len", last_len, 2);
    chk("flush_beats", hs_total - h0, 2);
    chk("flush_pad_beat", last_data, pad_exp);
    chk("flush_pad_keep", last_keep, 4'b0011);
    chk("flush_done_once", n_flush_done - f0, 1);

    do_flush(1'b0, lat);
    chk("empty_flush_latency", lat <= 3, 1'b1);

    // fill the ring with the DMA holding off
    b0 = n_bursts; ack_mode = 0; rdy_mode = 0;
    drive_words(1024, 100, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1 chk("ring_full_in_ready", in_ready, 1'b0);
    chk("ring_full_req", burst_req, 1'b1);
    ack_mode = 1;
    wait_drain(3000);
    @(posedge clk); #1 chk("ring_drained_in_ready", in_ready, 1'b1);
    chk("ring_bursts", n_bursts - b0, 2);

    // out_ready toggling every cycle
    h0 = hs_total; rdy_mode = 1; ack_mode = 1;
    drive_words(512, 70, 1'b0, 0);
    do_flush(1'b0, lat);
    chk("bp_beats", hs_total - h0, 128);

    // three random bursts across the pointer wrap
    b0 = n_bursts; h0 = hs_total; rdy_mode = 2; ack_mode = 2;
    drive_words(1536, 80, 1'b0, 0);
    do_flush(1'b0, lat);
    chk("wrap_bursts", n_bursts - b0, 3);
    chk("wrap_beats", hs_total - h0, 384);

    // reset in the middle of a burst
    h0 = hs_total; rdy_mode = 0; ack_mode = 1;
    fork
      drive_words(512, 100, 1'b1, 0);
      begin
        int cyc = 0;
        while (hs_total - h0 < 50 && cyc < 5000) begin
          @(posedge clk); cyc++;
        end
        chk("midburst_reach_50", hs_total - h0 >= 50, 1'b1);
        #2 rst = 1'b1;
        abort = 1;
        #1 check_reset_outputs("midreset");
        model_reset();
      end
    join
    repeat (2) @(posedge clk);
    #3 check_reset_outputs("midreset_hold");
    abort = 0;
    @(negedge clk) rst = 1'b0;
    full_burst_test("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/result_pack_buffer.md
# result_pack_buffer

Output-side ring buffer for the VRSM accelerator. It accepts one DATA_WIDTH result word per cycle from the compute pipeline and packs NUM_LANE words into each beat. It stores the beats in a ring and hands them to the DMA write engine as bursts of up to BURST_LENGTH beats, using a request/ack handshake followed by a valid/ready beat stream. A flush drains a partial beat and a partial burst at the end of a job.

## Interface
- DATA_WIDTH, 32, bits per result word
- NUM_LANE, 4, words per beat (power of two)
- BURST_LENGTH, 128, max beats per DMA burst
- DEPTH_BEATS, 256, ring capacity in beats (power of two, at least BURST_LENGTH)
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  din valid
- in_ready  out  1  word accepted when in_valid && in_ready
- din  in  DATA_WIDTH  result word
- flush  in  1  one-cycle pulse: pad the partial beat, drain all stored beats
- flush_done  out  1  one-cycle pulse when the flush has completed
- burst_req  out  1  DMA burst request
- burst_len  out  $clog2(BURST_LENGTH)+1  beats in the requested burst
- burst_ack  in  1  DMA accepts the request
- out_valid  out  1  beat valid
- out_ready  in  1  DMA consumes the beat
- dout  out  NUM_LANE*DATA_WIDTH  packed beat; lane i = word i in arrival order
- out_keep  out  NUM_LANE  lane-valid mask
- out_last  out  1  final beat of the current burst

## Operation
- **Packing**
  - The staging register fills lane_idx = 0..NUM_LANE-1 from accepted words.
  - When lane NUM_LANE-1 is accepted, the beat is written to mem[wptr] with keep = all ones; wptr increments and count increments.
- **Input backpressure:** in_ready = (count < DEPTH_BEATS) && !flush_pending.
- **Pointers:** wptr and rptr are $clog2(DEPTH_BEATS) bits and wrap naturally. count is $clog2(DEPTH_BEATS)+1 bits. A simultaneous commit and pop leaves count unchanged.
- **FSM states:** IDLE, REQ, XFER.
  - IDLE -> REQ when count >= BURST_LENGTH. burst_len = BURST_LENGTH.
  - IDLE -> REQ when flush_pending && no staged words && count > 0. burst_len = min(count, BURST_LENGTH).
  - REQ holds burst_req=1 with burst_len stable. REQ -> XFER when burst_ack is high.
  - XFER streams burst_len beats from rptr. XFER -> IDLE on the edge that accepts the beat with out_last.
- **Flush sequence**
  - A flush pulse sets flush_pending.
  - If lane_idx > 0, the partial beat is zero-padded and committed with keep = (1<<lane_idx)-1 once count < DEPTH_BEATS.
  - Bursts repeat until count == 0. flush_pending then clears and flush_done pulses.
  - A flush that arrives while flush_pending is already set is ignored.
  - A flush with nothing stored gives flush_done on the next cycle.
- **Output stage:** a registered beat is loaded from mem[rptr] (data + keep) while in XFER with beats remaining and the stage empty or being consumed. Loading decrements count and increments rptr.

## Timing
- **Reset values:** in_ready=1, flush_done=0, burst_req=0, burst_len=0, out_valid=0, dout=0, out_keep=0, out_last=0. Pointers, count, lane_idx, flush_pending = 0; FSM = IDLE.
- **Beat commit:** the last word is accepted at edge t; count reflects the beat after t.
- **Burst request:** burst_req rises one cycle after count reaches the threshold.
- **First beat:** out_valid rises on the edge after the one that samples burst_ack.
- **Throughput:** back-to-back beats with out_ready held high, no bubbles. A beat stays stable while out_valid && !out_ready.
- **Ordering:** a burst is never started while another is in XFER. burst_ack outside REQ is ignored.
- **Reset mid-burst:** returns to reset values immediately; contents are discarded.

## Configuration
- **RESULT_PACK_STATUS_EN defined:** adds two outputs.
  - level (out, $clog2(DEPTH_BEATS)+1): count, registered.
  - burst_cnt (out, 16): bursts completed, wraps at 2^16.
  - Both reset to 0.
- **Undefined:** neither port nor the counter exists; the remaining behaviour is identical.

## Structure
- Package vrsm_buf_pkg holds:
  - typedef fsm_t {IDLE, REQ, XFER}
  - the beat typedef (logic [NUM_LANE-1:0][DATA_WIDTH-1:0])
  - localparam helpers for pointer and count widths
- One sub-module, pack_stage: the staging register, lane_idx, padding and keep generation. It outputs a commit strobe, the beat and its keep.

## Test plan
- **Full burst:** 512 words, out_ready=1, immediate ack.
  - burst_req once, burst_len=128.
  - 128 beats; beat 0 = words 0..3.
  - out_last on beat 128, all keep=4'hF.
- **Flush with partial beat:** 6 words then flush.
  - 1 burst, burst_len=2.
  - Beat 2 holds words 4,5 in lanes 0,1 with lanes 2,3 = 0 and keep=4'b0011.
  - flush_done after out_last.
- **Full ring:** 1024 words, burst_ack held low.
  - in_ready drops after word 1024; count=256.
  - Ack, then 2 bursts drain and in_ready returns.
- **Backpressure:** toggle out_ready every cycle.
  - Beats stay stable while stalled.
  - No loss or duplication over 128 beats.
- **Pointer wrap:** 3 full bursts.
  - The burst crossing rptr 255 -> 0 outputs data in sequence.
- **Reset mid-burst:** rst at beat 50.
  - All outputs go to reset values.
  - A subsequent 512-word run passes the full-burst check.
